// File: rtl/memory_s_sp_2048_x_8_word_master.sv
// Word-to-byte initiator for the 2048x8 single-port SRAM: splits one 32-bit client
// access into four byte accesses and reassembles read bytes into a word.
module memory_s_sp_2048_x_8_word_master #(
    parameter int unsigned SramAddrWidth = 11
) (
    input  logic                     sram_clock_i,
    input  logic                     sram_reset_n_i,
    input  logic                     client_req_i,
    input  logic                     client_write_i,
    input  logic [SramAddrWidth-3:0] client_address_i,
    input  logic [3:0]               client_byte_enables_i,
    input  logic [31:0]              client_write_data_i,
    output logic                     client_ack_o,
    output logic [31:0]              client_read_data_o,
    output logic                     client_busy_o,
    output logic                     sram_read_o,
    output logic                     sram_write_o,
    output logic [SramAddrWidth-1:0] sram_address_o,
    output logic [7:0]               sram_write_data_o,
    input  logic [7:0]               sram_read_data_i
);

    typedef enum logic [1:0] {StIdle, StAccess, StReadTail, StAck} state_e;

    state_e                   state_q, state_d;
    logic [1:0]               lane_q, lane_d;
    logic                     write_q, write_d;
    logic [SramAddrWidth-3:0] addr_q, addr_d;
    logic [3:0]               be_q, be_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [31:0]              rdata_q, rdata_d;
    logic [1:0]               cap_lane;

    always_ff @(posedge sram_clock_i or negedge sram_reset_n_i) begin
        if (!sram_reset_n_i) begin
            state_q <= StIdle;
            lane_q  <= 2'd0;
            write_q <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Read data lags the strobe by one cycle, so it belongs to the previous lane.
    assign cap_lane = lane_q - 2'd1;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        write_d = write_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (client_req_i) begin
                    write_d = client_write_i;
                    addr_d  = client_address_i;
                    be_d    = client_byte_enables_i;
                    wdata_d = client_write_data_i;
                    lane_d  = 2'd0;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                lane_d = lane_q + 2'd1;
                if (!write_q && lane_q != 2'd0) begin
                    rdata_d[{cap_lane, 3'b000} +: 8] = sram_read_data_i;
                end
                if (lane_q == 2'd3) begin
                    state_d = write_q ? StAck : StReadTail;
                end
            end
            StReadTail: begin
                rdata_d[31:24] = sram_read_data_i;
                state_d        = StAck;
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // SRAM side is decoded from registered state only.
    always_comb begin
        sram_read_o       = 1'b0;
        sram_write_o      = 1'b0;
        sram_address_o    = '0;
        sram_write_data_o = 8'd0;
        if (state_q == StAccess) begin
            sram_address_o = {addr_q, lane_q};
            if (write_q) begin
                sram_write_o      = be_q[lane_q];
                sram_write_data_o = wdata_q[{lane_q, 3'b000} +: 8];
            end else begin
                sram_read_o = 1'b1;
            end
        end
    end

    assign client_ack_o       = (state_q == StAck);
    assign client_busy_o      = (state_q != StIdle);
    assign client_read_data_o = rdata_q;

endmodule

// File: tb/tb_memory_s_sp_2048_x_8_word_master.sv
// Self-checking bench for the word master: behavioural 2048x8 SRAM plus a per-cycle
// scoreboard of expected SRAM-bus and client-handshake values.
module tb_memory_s_sp_2048_x_8_word_master;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        wr;
    logic [8:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        busy;
    logic        s_rd;
    logic        s_wr;
    logic [10:0] s_addr;
    logic [7:0]  s_wdata;
    logic [7:0]  s_rdata;

    logic [7:0]  mem [2048];

    int n_vec;
    int n_err;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        ack;
        logic        busy;
        logic [10:0] addr;
        logic [7:0]  wdata;
        logic        chk_wd;
    } cyc_t;

    cyc_t exp_q[$];

    memory_s_sp_2048_x_8_word_master #(
        .SramAddrWidth(11)
    ) dut (
        .sram_clock_i         (clk),
        .sram_reset_n_i       (rst_n),
        .client_req_i         (req),
        .client_write_i       (wr),
        .client_address_i     (addr),
        .client_byte_enables_i(be),
        .client_write_data_i  (wdata),
        .client_ack_o         (ack),
        .client_read_data_o   (rdata),
        .client_busy_o        (busy),
        .sram_read_o          (s_rd),
        .sram_write_o         (s_wr),
        .sram_address_o       (s_addr),
        .sram_write_data_o    (s_wdata),
        .sram_read_data_i     (s_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: write on the edge, read data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (s_wr) mem[s_addr] <= s_wdata;
        s_rdata <= s_rd ? mem[s_addr] : 8'h00;
    end

    // Called at a negedge in an IDLE cycle; returns at the negedge of the next IDLE cycle.
    task automatic run_xact(input logic w, input logic [8:0] a, input logic [3:0] b,
                            input logic [31:0] d, input logic [31:0] exp_rd,
                            input bit keep_req, input string name);
        int   n;
        cyc_t e;
        cyc_t g;
        logic [1:0] ln;
        n = w ? 6 : 7;
        for (int c = 1; c <= n; c++) begin
            e = '0;
            if (c <= 4) begin
                ln     = 2'(c - 1);
                e.addr = {a, ln};
                e.busy = 1'b1;
                if (w) begin
                    e.wr     = b[ln];
                    e.wdata  = d[8*ln +: 8];
                    e.chk_wd = 1'b1;
                end else begin
                    e.rd = 1'b1;
                end
            end else if (c < n - 1) begin
                e.busy = 1'b1;
            end else if (c == n - 1) begin
                e.ack  = 1'b1;
                e.busy = 1'b1;
            end
            exp_q.push_back(e);
        end
        wr    = w;
        addr  = a;
        be    = b;
        wdata = d;
        req   = 1'b1;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (!keep_req) req = 1'b0;
            e = exp_q.pop_front();
            g = '0;
            g.rd     = s_rd;
            g.wr     = s_wr;
            g.ack    = ack;
            g.busy   = busy;
            g.addr   = s_addr;
            g.wdata  = e.chk_wd ? s_wdata : 8'h00;
            g.chk_wd = e.chk_wd;
            n_vec++;
            if (g !== e) begin
                n_err++;
                $display("FAIL %s cycle %0d: got rd=%b wr=%b ack=%b busy=%b addr=%h wd=%h, want rd=%b wr=%b ack=%b busy=%b addr=%h wd=%h",
                         name, c, g.rd, g.wr, g.ack, g.busy, g.addr, g.wdata,
                         e.rd, e.wr, e.ack, e.busy, e.addr, e.wdata);
            end
            if (!w && e.ack) begin
                n_vec++;
                if (rdata !== exp_rd) begin
                    n_err++;
                    $display("FAIL %s read data: got %h want %h", name, rdata, exp_rd);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 1'b0;
        wr    = 1'b0;
        addr  = '0;
        be    = '0;
        wdata = '0;
        #1;
        n_vec++;
        if ({ack, busy, s_rd, s_wr, s_addr, s_wdata, rdata} !== 55'd0) begin
            n_err++;
            $display("FAIL reset outputs: got ack=%b busy=%b rd=%b wr=%b addr=%h wd=%h rdata=%h want all 0",
                     ack, busy, s_rd, s_wr, s_addr, s_wdata, rdata);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_word();
        run_xact(1'b1, 9'h005, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, "write_005");
        run_xact(1'b0, 9'h005, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, "read_005");
    endtask

    task automatic test_partial_write();
        run_xact(1'b1, 9'h006, 4'hF, 32'h11223344, 32'h0, 1'b0, "partial_full");
        run_xact(1'b1, 9'h006, 4'h5, 32'hAABBCCDD, 32'h0, 1'b0, "partial_be5");
        run_xact(1'b0, 9'h006, 4'h0, 32'h0, 32'h11BB33DD, 1'b0, "partial_read");
    endtask

    task automatic test_top_word();
        run_xact(1'b1, 9'h1FF, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, "top_write");
        run_xact(1'b0, 9'h1FF, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, "top_read");
    endtask

    task automatic test_back_to_back();
        run_xact(1'b1, 9'h0A0, 4'hF, 32'h12345678, 32'h0, 1'b1, "b2b_w0");
        run_xact(1'b0, 9'h0A0, 4'h0, 32'h0, 32'h12345678, 1'b1, "b2b_r0");
        run_xact(1'b1, 9'h0A1, 4'hF, 32'h9ABCDEF0, 32'h0, 1'b1, "b2b_w1");
        run_xact(1'b0, 9'h0A1, 4'h0, 32'h0, 32'h9ABCDEF0, 1'b0, "b2b_r1");
    endtask

    task automatic test_mid_write_reset();
        run_xact(1'b1, 9'h010, 4'hF, 32'hAAAAAAAA, 32'h0, 1'b0, "mw_prefill");
        wr    = 1'b1;
        addr  = 9'h010;
        be    = 4'hF;
        wdata = 32'h01020304;
        req   = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({ack, busy, s_rd, s_wr, s_addr, s_wdata, rdata} !== 55'd0) begin
            n_err++;
            $display("FAIL mid_write_reset outputs: got ack=%b busy=%b rd=%b wr=%b addr=%h wd=%h rdata=%h want all 0",
                     ack, busy, s_rd, s_wr, s_addr, s_wdata, rdata);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (ack !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL mid_write_reset hold %0d: got ack=%b busy=%b want 0 0", i, ack, busy);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_xact(1'b0, 9'h010, 4'h0, 32'h0, 32'hAAAA0304, 1'b0, "mw_readback");
    endtask

    task automatic test_mid_read_reset();
        wr    = 1'b0;
        addr  = 9'h005;
        req   = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (rdata !== 32'h0 || ack !== 1'b0 || s_rd !== 1'b0) begin
            n_err++;
            $display("FAIL mid_read_reset: got rdata=%h ack=%b rd=%b want 0 0 0", rdata, ack, s_rd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_be();
        run_xact(1'b1, 9'h020, 4'hF, 32'h55667788, 32'h0, 1'b0, "zbe_prefill");
        run_xact(1'b1, 9'h020, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0, "zbe_write");
        run_xact(1'b0, 9'h020, 4'h0, 32'h0, 32'h55667788, 1'b0, "zbe_read");
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        test_reset();
        test_full_word();
        test_partial_write();
        test_top_word();
        test_back_to_back();
        test_mid_write_reset();
        test_mid_read_reset();
        test_zero_be();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
